// File: rtl/tanh_arbiter.sv
// tanh_arbiter: round-robin / fixed-priority sharing of one tanh unit among N
// requesters. It captures the winner's operand, runs the Start/Ready
// handshake and returns the registered result with a one-cycle done pulse.
// Optional feature macro: TANH_ARB_RR_EN (defined = round-robin,
// undefined = fixed priority, lowest index wins).
module tanh_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   r_out,
  output logic [2:0]     r_id,
  output logic           busy,
  output logic           t_start,
  output logic [W-1:0]   t_xBus,
  input  logic           t_ready,
  input  logic [W-1:0]   t_rBus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAITBUSY = 3'd2,
    WAITDONE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   gnt_reg, done_reg;
  logic [W-1:0]   r_out_reg, xreg_reg;
  logic [2:0]     r_id_reg, win_reg;
  logic [2:0]     search_base;
  logic [7:0]     req_pad;
  logic           sel_valid;
  logic [2:0]     sel_idx;
  logic [N-1:0]   sel_onehot;
  logic           grant_go, result_go;
  logic [W-1:0]   x_arr [8];

  // Pad requests to 8 entries so a 3-bit index always selects in range.
  assign req_pad = 8'(req);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_xslice
      if (gi < N) begin : g_used
        assign x_arr[gi] = x_in[gi*W +: W];
      end else begin : g_unused
        assign x_arr[gi] = '0;
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_idx == 3'(gi));
    end
  endgenerate

`ifdef TANH_ARB_RR_EN
  logic [2:0] ptr_reg;
  assign search_base = ptr_reg;

  // Round-robin pointer: remembers the last served requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_reg <= 3'(N-1);
    else if (state_reg == DONE)
      ptr_reg <= win_reg;
  end
`else
  // Fixed priority is a search that always starts just after N-1, i.e. at 0.
  assign search_base = 3'(N-1);
`endif

  // Winner search: first asserted request after search_base, wrapping mod N.
  always_comb begin
    logic [3:0] cand;
    sel_valid = 1'b0;
    sel_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, search_base} + 4'(k);
      if (cand >= 4'(N))
        cand = cand - 4'(N);
      if (!sel_valid && req_pad[cand[2:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    grant_go   = 1'b0;
    result_go  = 1'b0;
    busy       = 1'b1;
    t_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (sel_valid && t_ready) begin
          grant_go   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        t_start    = 1'b1;
        state_next = WAITBUSY;
      end
      WAITBUSY: begin
        if (!t_ready)
          state_next = WAITDONE;
      end
      WAITDONE: begin
        if (t_ready) begin
          result_go  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Grant/operand capture, result capture and done pulse generation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_reg   <= '0;
      done_reg  <= '0;
      r_out_reg <= '0;
      r_id_reg  <= 3'd0;
      xreg_reg  <= '0;
      win_reg   <= 3'd0;
    end else begin
      done_reg <= '0;
      if (grant_go) begin
        gnt_reg  <= sel_onehot;
        win_reg  <= sel_idx;
        xreg_reg <= x_arr[sel_idx];
      end
      if (result_go) begin
        r_out_reg <= t_rBus;
        r_id_reg  <= win_reg;
        done_reg  <= gnt_reg;
      end
      if (state_reg == DONE)
        gnt_reg <= '0;
    end
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign r_out  = r_out_reg;
  assign r_id   = r_id_reg;
  assign t_xBus = xreg_reg;

endmodule

// File: tb/tb_tanh_arbiter.sv
// Bench for tanh_arbiter: tanh stub (~x after 6 busy cycles), a negedge
// monitor that records grants/dones, and a service-order reference model.
module tb_tanh_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x_in = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   r_out, t_xBus, t_rBus;
  logic [2:0]     r_id;
  logic           busy, t_start, t_ready;
  logic           ext_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tanh_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt), .done(done),
    .r_out(r_out), .r_id(r_id), .busy(busy), .t_start(t_start),
    .t_xBus(t_xBus), .t_ready(t_ready), .t_rBus(t_rBus)
  );

  // tanh stub: on Start drop Ready for 6 cycles, then return ~xBus.
  logic         s_ready;
  int           s_cnt;
  logic [W-1:0] s_r;
  assign t_ready = s_ready & ~ext_busy;
  assign t_rBus  = s_r;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready <= 1'b1; s_cnt <= 0; s_r <= '0;
    end else if (s_ready) begin
      if (t_start) begin s_ready <= 1'b0; s_cnt <= 6; end
    end else begin
      if (s_cnt == 1) begin s_ready <= 1'b1; s_r <= ~t_xBus; end
      s_cnt <= s_cnt - 1;
    end
  end

  // Monitor: records transactions and protocol violations on the falling edge.
  int           gnt_ids[$];
  logic [W-1:0] gnt_xs[$];
  logic [N-1:0] done_vecs[$];
  logic [W-1:0] done_rs[$];
  logic [2:0]   done_ids[$];
  int viol_onehot = 0, viol_start = 0, viol_xbus = 0, viol_busy = 0, viol_done = 0, start_cnt = 0;
  logic [N-1:0] prev_gnt = '0, prev_done = '0;
  logic [W-1:0] grant_x = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_gnt = '0; prev_done = '0;
    end else begin
      if (gnt != 0 && !$onehot(gnt)) viol_onehot++;
      if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) viol_onehot++;
      if (gnt != 0 && prev_gnt == 0) begin
        int id = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) id = i;
        gnt_ids.push_back(id);
        gnt_xs.push_back(t_xBus);
        grant_x = t_xBus;
        if (t_start !== 1'b1) viol_start++;
      end else if (t_start !== 1'b0) viol_start++;
      if (t_start === 1'b1) start_cnt++;
      if (gnt != 0 && t_xBus !== grant_x) viol_xbus++;
      if (busy !== (gnt != 0)) viol_busy++;
      if (prev_done != 0 && (busy !== 1'b0 || gnt != 0)) viol_busy++;
      if (done != 0) begin
        if (done !== gnt || prev_done != 0) viol_done++;
        done_vecs.push_back(done); done_rs.push_back(r_out); done_ids.push_back(r_id);
      end
      prev_gnt = gnt; prev_done = done;
    end
  end

  // Reference model: which requester the arbitration rule serves next.
  int model_last = N-1;
  function automatic int model_pick(input logic [N-1:0] m, input int last);
`ifdef TANH_ARB_RR_EN
    for (int off = 1; off <= N; off++) if (m[(last+off)%N]) return (last+off)%N;
`else
    for (int i = 0; i < N; i++) if (m[i]) return i;
`endif
    return -1;
  endfunction

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clear_mon();
    gnt_ids.delete(); gnt_xs.delete(); done_vecs.delete(); done_rs.delete(); done_ids.delete();
    viol_onehot = 0; viol_start = 0; viol_xbus = 0; viol_busy = 0; viol_done = 0; start_cnt = 0;
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int c = 0;
    while (done_vecs.size() < n && c < budget) begin step(); c++; end
    ok = (done_vecs.size() >= n);
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    int c = 0;
    while (gnt == 0 && c < budget) begin step(); c++; end
    ok = (gnt != 0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    model_last = N-1;
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (r_out !== 16'h0) begin errors++; $display("FAIL reset_r_out: got %h expected 0000", r_out); end
    checks++; if (r_id !== 3'd0) begin errors++; $display("FAIL reset_r_id: got %0d expected 0", r_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (t_start !== 1'b0) begin errors++; $display("FAIL reset_t_start: got %b expected 0", t_start); end
    checks++; if (t_xBus !== 16'h0) begin errors++; $display("FAIL reset_t_xBus: got %h expected 0000", t_xBus); end
    $display("reset: outputs gnt=%b done=%b r_out=%h busy=%b", gnt, done, r_out, busy);
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    x_in = {$urandom, $urandom};
    x_in[0 +: W] = 16'h1234;
    req = 4'b0001;
    wait_dones(1, 40, ok);
    req = '0;
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d dones expected 1", done_vecs.size()); end
    if (ok) begin
      checks++; if (gnt_xs[0] !== 16'h1234) begin errors++; $display("FAIL single_xbus: got %h expected 1234", gnt_xs[0]); end
      checks++; if (done_vecs[0] !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done_vecs[0]); end
      checks++; if (done_rs[0] !== 16'hEDCB) begin errors++; $display("FAIL single_r_out: got %h expected EDCB", done_rs[0]); end
      checks++; if (done_ids[0] !== 3'd0) begin errors++; $display("FAIL single_r_id: got %0d expected 0", done_ids[0]); end
    end
    step(); step(); step();
    checks++; if (start_cnt != 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", start_cnt); end
    checks++; if (r_out !== 16'hEDCB) begin errors++; $display("FAIL single_r_out_hold: got %h expected EDCB", r_out); end
    checks++; if (gnt_ids.size() != 1) begin errors++; $display("FAIL single_grants: got %0d expected 1", gnt_ids.size()); end
    checks++; if (viol_start + viol_xbus + viol_busy + viol_done + viol_onehot != 0) begin
      errors++; $display("FAIL single_protocol: got start=%0d xbus=%0d busy=%0d done=%0d onehot=%0d expected all 0",
                         viol_start, viol_xbus, viol_busy, viol_done, viol_onehot); end
    model_last = 0;
    $display("single: done=%b r_out=%h r_id=%0d", done_vecs.size() > 0 ? done_vecs[0] : 4'b0, r_out, r_id);
  endtask

  task automatic test_all_requesting();
    bit ok;
    clear_mon();
    for (int i = 0; i < N; i++) x_in[i*W +: W] = 16'(16'h0100 * i);
    req = 4'b1111;
    wait_dones(5, 100, ok);
    req = '0;
    step(); step(); step();
    checks++; if (!ok || gnt_ids.size() != 5) begin errors++; $display("FAIL all_count: got %0d grants expected 5", gnt_ids.size()); end
    if (ok && gnt_ids.size() == 5) begin
      for (int t = 0; t < 5; t++) begin
        int e = model_pick(4'b1111, model_last);
        checks++; if (gnt_ids[t] != e || done_ids[t] !== 3'(e) || done_vecs[t] !== 4'(1 << e) || done_rs[t] !== ~16'(16'h0100 * e)) begin
          errors++; $display("FAIL all_txn%0d: got id=%0d done=%b r_out=%h expected id=%0d r_out=%h",
                             t, gnt_ids[t], done_vecs[t], done_rs[t], e, ~16'(16'h0100 * e)); end
        $display("all: txn %0d served %0d r_out=%h", t, gnt_ids[t], done_rs[t]);
        model_last = e;
      end
    end
    checks++; if (viol_onehot + viol_busy + viol_done + viol_start != 0) begin
      errors++; $display("FAIL all_protocol: got onehot=%0d busy=%0d done=%0d start=%0d expected all 0",
                         viol_onehot, viol_busy, viol_done, viol_start); end
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] mask;
      int k;
      clear_mon();
      mask = 4'($urandom_range(1, 15));
      k = $urandom_range(1, 4);
      x_in = {$urandom, $urandom};
      req = mask;
      wait_dones(k, 20 * k + 20, ok);
      req = '0;
      step(); step();
      checks++; if (!ok || done_ids.size() != k) begin errors++; $display("FAIL rand%0d_count: got %0d dones expected %0d", r, done_ids.size(), k); end
      if (ok && done_ids.size() == k) begin
        for (int t = 0; t < k; t++) begin
          int e = model_pick(mask, model_last);
          checks++; if (done_ids[t] !== 3'(e) || done_rs[t] !== ~x_in[e*W +: W]) begin
            errors++; $display("FAIL rand%0d_txn%0d: got id=%0d r_out=%h expected id=%0d r_out=%h",
                               r, t, done_ids[t], done_rs[t], e, ~x_in[e*W +: W]); end
          $display("rand: round %0d mask=%b txn %0d served %0d", r, mask, t, done_ids[t]);
          model_last = e;
        end
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    logic [W-1:0] x2;
    clear_mon();
    x_in = {$urandom, $urandom};
    x2 = x_in[2*W +: W];
    req = 4'b0100;
    wait_gnt(40, ok);
    step();
    req = '0;
    wait_dones(1, 40, ok);
    repeat (15) step();
    checks++; if (done_vecs.size() != 1 || done_vecs[0] !== 4'b0100) begin
      errors++; $display("FAIL drop_done: got %0d dones expected one 0100", done_vecs.size()); end
    else begin
      checks++; if (done_rs[0] !== ~x2) begin errors++; $display("FAIL drop_r_out: got %h expected %h", done_rs[0], ~x2); end
    end
    checks++; if (gnt_ids.size() != 1) begin errors++; $display("FAIL drop_regrant: got %0d grants expected 1", gnt_ids.size()); end
    model_last = 2;
    $display("drop: grants=%0d dones=%0d r_out=%h", gnt_ids.size(), done_vecs.size(), r_out);
  endtask

  task automatic test_operand_hold();
    bit ok;
    logic [W-1:0] x3;
    clear_mon();
    x_in = {$urandom, $urandom};
    x3 = x_in[3*W +: W];
    req = 4'b1000;
    wait_gnt(40, ok);
    x_in[3*W +: W] = x3 ^ 16'h5A5A;
    wait_dones(1, 40, ok);
    req = '0;
    step();
    checks++; if (!ok || done_rs[0] !== ~x3) begin errors++; $display("FAIL hold_r_out: got %h expected %h", r_out, ~x3); end
    checks++; if (viol_xbus != 0 || gnt_xs.size() != 1 || gnt_xs[0] !== x3) begin
      errors++; $display("FAIL hold_xbus: got %0d xbus changes expected 0 with operand %h", viol_xbus, x3); end
    model_last = 3;
    $display("hold: operand %h r_out=%h", x3, r_out);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e0, e1;
    clear_mon();
    x_in = {$urandom, $urandom};
    req = 4'b0001;
    wait_gnt(40, ok);
    step(); step(); step();
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0 || busy !== 1'b0 || t_start !== 1'b0 || done !== 4'b0) begin
      errors++; $display("FAIL midrst_ctrl: got gnt=%b busy=%b t_start=%b done=%b expected 0", gnt, busy, t_start, done); end
    checks++; if (r_out !== 16'h0 || r_id !== 3'd0 || t_xBus !== 16'h0) begin
      errors++; $display("FAIL midrst_data: got r_out=%h r_id=%0d t_xBus=%h expected 0", r_out, r_id, t_xBus); end
    req = '0;
    step();
    rst = 1'b1;
    model_last = N-1;
    repeat (20) step();
    checks++; if (done_vecs.size() != 0) begin errors++; $display("FAIL midrst_nodone: got %0d dones expected 0", done_vecs.size()); end
    req = 4'b0010;
    wait_dones(1, 40, ok);
    req = '0;
    checks++; if (!ok || done_ids[0] !== 3'd1) begin errors++; $display("FAIL midrst_pending1: got %0d dones expected id 1", done_vecs.size()); end
    model_last = 1;
    step();
    clear_mon();
    rst = 1'b0; step(); rst = 1'b1;
    model_last = N-1;
    req = 4'b0011;
    wait_dones(2, 60, ok);
    req = '0;
    e0 = model_pick(4'b0011, model_last);
    e1 = model_pick(4'b0011, e0);
    checks++; if (!ok || done_ids[0] !== 3'(e0) || done_ids[1] !== 3'(e1)) begin
      errors++; $display("FAIL midrst_order: got %0d dones expected ids %0d,%0d", done_vecs.size(), e0, e1); end
    model_last = e1;
    $display("midrst: after release served %0d then %0d", e0, e1);
  endtask

  task automatic test_idle_busy();
    bit ok;
    clear_mon();
    step();
    ext_busy = 1'b1;
    req = 4'b0001;
    repeat (10) step();
    checks++; if (gnt_ids.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL extbusy_hold: got %0d grants busy=%b expected 0 grants busy=0", gnt_ids.size(), busy); end
    ext_busy = 1'b0;
    wait_dones(1, 40, ok);
    req = '0;
    checks++; if (!ok || done_ids[0] !== 3'(model_pick(4'b0001, model_last))) begin
      errors++; $display("FAIL extbusy_serve: got %0d dones expected id 0", done_vecs.size()); end
    model_last = 0;
    step(); step();
    $display("extbusy: grants=%0d after release", gnt_ids.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_random();
    test_drop();
    test_operand_hold();
    test_reset_mid();
    test_idle_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tanh_arbiter.md
# tanh_arbiter

Round-robin arbiter and sequencer that shares one `tanh` unit among `N` requesters. It captures the granted requester's operand and drives the `tanh` Start/Ready handshake: Start pulse, wait for busy, wait for Ready. It then latches the result and returns it to the requester with a one-cycle done pulse. It sits between the client blocks and a single `tanh` instance and owns that instance's `xBus`/`Start` inputs.

## Interface
- `N`, 4 — number of requesters, legal range 2..8.
- `W`, 16 — operand/result width; must match the `tanh` bus width.
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-low reset; the same net also resets the shared `tanh` instance.
- `req` input N — per-requester level request; held high until the matching `done`.
- `x_in` input N*W — packed operands; requester i uses bits [i*W +: W]. Sampled only at grant.
- `gnt` output N — one-hot; high from grant through the DONE cycle.
- `done` output N — one-cycle pulse to the served requester; `r_out` is valid in that cycle and holds until the next DONE.
- `r_out` output W — registered result.
- `r_id` output 3 — index of the requester whose result is on `r_out`.
- `busy` output 1 — high whenever the state is not IDLE.
- `t_start` output 1 — drives `tanh` Start.
- `t_xBus` output W — drives `tanh` xBus from the internal operand register.
- `t_ready` input 1 — from `tanh` Ready.
- `t_rBus` input W — from `tanh` rBus.

## Operation
- States: IDLE, START, WAITBUSY, WAITDONE, DONE. Encoding is 3-bit; unused codes go to IDLE.
- IDLE:
  - If `|req` and `t_ready`=1, select the winner, register one-hot `gnt`, and load `xreg` from the winner's `x_in` slice. Go to START.
  - Otherwise stay in IDLE.
- START: `t_start`=1 for exactly this cycle. Go to WAITBUSY.
- WAITBUSY: `t_start`=0. If `t_ready`=0, go to WAITDONE; otherwise stay.
- WAITDONE: stay while `t_ready`=0. When `t_ready`=1, load `r_out`←`t_rBus` and `r_id`←winner index, then go to DONE.
- DONE: `done[winner]`=1 for one cycle. Update the round-robin pointer to the winner. Clear `gnt` and go to IDLE on the next edge.
- `t_xBus`=`xreg` at all times. `xreg` changes only at grant, so the operand is stable for the whole `tanh` computation.
- Round-robin selection: search starts at `ptr+1` mod N and takes the first asserted `req`. `ptr` resets to N-1, so requester 0 wins first after reset.
- Dropping `req` while granted does not cancel the computation. The operation completes and `done` still pulses.
- A requester whose `req` is still high in the cycle after `done` is treated as a new request.
- `req` bits are not latched. A request that drops before it is granted is lost.
- Requests arriving while `busy`=1 wait; arbitration happens only in IDLE.

## Timing
- Reset values: `gnt`=0, `done`=0, `r_out`=0, `r_id`=0, `busy`=0, `t_start`=0, `xreg`=0, `ptr`=N-1, state=IDLE.
- Request seen in IDLE at edge k:
  - `gnt` and `busy` rise at k+1.
  - `t_start` is high during cycle k+1 only.
  - `tanh` drops Ready at k+2, so WAITBUSY normally lasts 1 cycle.
- Result: `done` pulses 1 cycle after the first cycle in which `t_ready`=1 is seen in WAITDONE.
- Total latency is 4 cycles plus the `tanh` busy time.
- Back-to-back service: the next grant can occur at the edge ending the IDLE cycle that follows DONE. There is a minimum of 1 IDLE cycle between operations.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous). No `done` is issued for the aborted request.
- `t_ready`=0 while in IDLE (unit externally busy): no grant, state holds.

## Configuration
- `TANH_ARB_RR_EN` defined: round-robin selection as described above.
- Not defined: fixed priority, lowest index wins. `ptr` is not implemented. All other behaviour and timing are unchanged.

## Test plan
The bench uses a `tanh` stub with identical Start/Ready protocol that returns ~x after 6 busy cycles.
- Single request: `req`=0001, x0=0x1234 → `t_start` pulses once; `t_xBus`=0x1234 throughout; `done`=0001 with `r_out`=0xEDCB and `r_id`=0; `busy` falls the cycle after DONE.
- All four requesting continuously with RR enabled, x_i=0x0100*i:
  - grants go 0,1,2,3,0 in order;
  - each `done` carries `r_out`=~x_i;
  - no `gnt` overlap, and `gnt` is always one-hot.
- Same stimulus with `TANH_ARB_RR_EN` undefined → requester 0 is served every time; the others never receive `done`.
- Requester 2 drops `req` one cycle after grant → `done`=0100 still pulses with the correct result; no re-grant of requester 2.
- `rst` asserted low in WAITDONE → outputs return to their reset values immediately and no `done` is issued. After release, a pending `req`=0010 is granted before requester 0 only if requester 0 is idle.
- `x_in` slice of the granted requester changed after grant → `t_xBus` and the result reflect the operand captured at grant.
